// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared clocked ALU.
// Grants one operation at a time, waits out the ALU latency and returns a tagged response.
module alu_req_arbiter #(
  parameter int DATA_W  = 16,
  parameter int FUN_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [FUN_W-1:0]  req0_fun,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [FUN_W-1:0]  req1_fun,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUN_W-1:0]  alu_fun,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [4:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_flags,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic              last_reg;
  logic              id_reg;
  logic              rej_reg;
  logic [2:0]        cnt_reg;
  logic [1:0]        valid_vec;
  logic [1:0]        ready_vec;
  logic              winner;
  logic              accept;
  logic              illegal;
  logic [DATA_W-1:0] win_a;
  logic [DATA_W-1:0] win_b;
  logic [FUN_W-1:0]  win_fun;

  assign valid_vec = {req1_valid, req0_valid};

  // On a tie the requester that was not granted last takes the slot.
  always_comb winner = (&valid_vec) ? ~last_reg : valid_vec[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = rst_n && (state_reg == IDLE) && valid_vec[gi] && (winner == 1'(gi));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign accept     = |ready_vec;

  assign win_a   = winner ? req1_a   : req0_a;
  assign win_b   = winner ? req1_b   : req0_b;
  assign win_fun = winner ? req1_fun : req0_fun;

  assign illegal = ((win_fun == FUN_W'(3)) && (win_b == '0)) || (win_fun == {FUN_W{1'b1}});

  assign rsp_valid = (state_reg == RESP);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    if (cnt_reg == 3'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Rejected ops spend one EXEC cycle with the ALU untouched, so their
  // response timing matches that of a zero-latency operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      id_reg    <= 1'b0;
      rej_reg   <= 1'b0;
      cnt_reg   <= 3'd0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= '0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        id_reg   <= winner;
        last_reg <= winner;
        rej_reg  <= illegal;
        if (illegal) begin
          cnt_reg <= 3'd0;
        end else begin
          cnt_reg <= 3'(ALU_LAT);
          alu_a   <= win_a;
          alu_b   <= win_b;
          alu_fun <= win_fun;
        end
      end else if (state_reg == EXEC) begin
        if (cnt_reg == 3'd0) begin
          rsp_id    <= id_reg;
          rsp_data  <= rej_reg ? '0 : alu_out;
          rsp_flags <= rej_reg ? '0 : alu_flags;
          rsp_err   <= rej_reg;
        end else begin
          cnt_reg <= cnt_reg - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alu_req_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Main DUT, ALU_LAT = 1
  logic        r0v = 0, r1v = 0, r0rdy, r1rdy;
  logic [15:0] r0a = 0, r0b = 0, r1a = 0, r1b = 0;
  logic [3:0]  r0f = 0, r1f = 0;
  logic [15:0] alu_a, alu_b, alu_out, rsp_data;
  logic [3:0]  alu_fun;
  logic [4:0]  alu_flags, rsp_flags;
  logic        rsp_v, rsp_rdy = 1, rsp_id, rsp_err;

  // Second DUT, ALU_LAT = 3
  logic        s_v = 0, s_rdy, s1_rdy, s1_v = 0;
  logic [15:0] s_a = 0, s_b = 0, s1_a = 0, s1_b = 0;
  logic [3:0]  s_f = 0, s1_f = 0;
  logic [15:0] s_alu_a, s_alu_b, s_alu_out, s_rsp_data;
  logic [3:0]  s_alu_fun;
  logic [4:0]  s_alu_flags, s_rsp_flags;
  logic        s_rsp_v, s_rsp_rdy = 1, s_rsp_id, s_rsp_err;

  alu_req_arbiter #(.DATA_W(16), .FUN_W(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_fun(r0f),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_fun(r1f),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_v), .rsp_ready(rsp_rdy), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  alu_req_arbiter #(.DATA_W(16), .FUN_W(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s_v), .req0_ready(s_rdy), .req0_a(s_a), .req0_b(s_b), .req0_fun(s_f),
    .req1_valid(s1_v), .req1_ready(s1_rdy), .req1_a(s1_a), .req1_b(s1_b), .req1_fun(s1_f),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_fun(s_alu_fun), .alu_out(s_alu_out), .alu_flags(s_alu_flags),
    .rsp_valid(s_rsp_v), .rsp_ready(s_rsp_rdy), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data),
    .rsp_flags(s_rsp_flags), .rsp_err(s_rsp_err)
  );

  // Reference ALU: returns {flags, result}; flags = {C, Arith, Logic, CMP, Shift}
  function automatic logic [20:0] alu_f(logic [15:0] a, logic [15:0] b, logic [3:0] f);
    logic [16:0] w;
    logic [15:0] r;
    logic [4:0]  fl;
    w = '0; r = '0; fl = '0;
    case (f)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; fl = {w[16], 4'b1000}; end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; fl = {w[16], 4'b1000}; end
      4'd2: begin r = a * b; fl = 5'b01000; end
      4'd3: begin r = (b != 0) ? a / b : 16'd0; fl = 5'b01000; end
      4'd4: begin r = a & b; fl = 5'b00100; end
      4'd5: begin r = a | b; fl = 5'b00100; end
      4'd6: begin r = a ^ b; fl = 5'b00100; end
      4'd7: begin r = {15'd0, a > b}; fl = 5'b00010; end
      4'd8: begin r = a << b[3:0]; fl = 5'b00001; end
      default: ;
    endcase
    return {fl, r};
  endfunction

  logic [20:0] p1 = '0;
  logic [20:0] p3 [3] = '{default: '0};
  always @(posedge clk) begin
    p1    <= alu_f(alu_a, alu_b, alu_fun);
    p3[0] <= alu_f(s_alu_a, s_alu_b, s_alu_fun);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {alu_flags, alu_out}     = p1;
  assign {s_alu_flags, s_alu_out} = p3[2];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  // Transaction model of the ALU_LAT=1 instance: busy flag, cycles since accept,
  // expected response and the ALU operands of the last legal op.
  bit          m_busy = 0, m_last = 1, m_id = 0, m_err = 0;
  int          m_t = 0, m_lat = 0;
  logic [15:0] m_data = 0, m_aa = 0, m_ab = 0;
  logic [4:0]  m_flags = 0;
  logic [3:0]  m_af = 0;
  bit          mw, me0, me1, mev, mill;
  logic [15:0] mpa, mpb;
  logic [3:0]  mpf;
  logic [20:0] mres;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_last = 1; m_aa = 0; m_ab = 0; m_af = 0;
    end else begin
      mw  = (r0v && r1v) ? !m_last : r1v;
      me0 = !m_busy && r0v && !mw;
      me1 = !m_busy && r1v && mw;
      mev = m_busy && (m_t >= m_lat + 1);
      chk("req0_ready", r0rdy, me0);
      chk("req1_ready", r1rdy, me1);
      chk("rsp_valid", rsp_v, mev);
      if (mev) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_flags", rsp_flags, m_flags);
        chk("rsp_err", rsp_err, m_err);
      end
      chk("alu_a", alu_a, m_aa);
      chk("alu_b", alu_b, m_ab);
      chk("alu_fun", alu_fun, m_af);
      if (me0 || me1) begin
        mpa  = mw ? r1a : r0a;
        mpb  = mw ? r1b : r0b;
        mpf  = mw ? r1f : r0f;
        mill = (mpf == 4'd3 && mpb == 0) || mpf == 4'hF;
        mres = mill ? 21'd0 : alu_f(mpa, mpb, mpf);
        m_busy = 1; m_t = 0; m_lat = mill ? 0 : 1;
        m_id = mw; m_last = mw; m_err = mill;
        {m_flags, m_data} = mres;
        if (!mill) begin m_aa = mpa; m_ab = mpb; m_af = mpf; end
      end else if (mev) begin
        if (rsp_rdy) m_busy = 0;
      end else if (m_busy) begin
        m_t++;
      end
    end
  end

  typedef struct {bit id; logic [15:0] data; logic [4:0] flags; bit err; int lat;} rsp_t;
  rsp_t rq[$];
  int   hs_cyc [2] = '{0, 0};
  int   rise_cyc = 0;
  bit   prev_v = 0;
  bit   refill = 0;

  // One clock: log responses, then drop (or refill) accepted requests.
  task automatic step();
    bit   a0, a1;
    rsp_t r;
    @(negedge clk);
    a0 = r0v && r0rdy;
    a1 = r1v && r1rdy;
    if (rsp_v && !prev_v) rise_cyc = cyc;
    prev_v = rsp_v;
    if (rsp_v && rsp_rdy) begin
      r.id = rsp_id; r.data = rsp_data; r.flags = rsp_flags; r.err = rsp_err;
      r.lat = rise_cyc - hs_cyc[rsp_id];
      rq.push_back(r);
      $display("rsp id=%0d data=%h flags=%b err=%0d lat=%0d", r.id, r.data, r.flags, r.err, r.lat);
    end
    @(posedge clk); #1;
    if (a0) begin hs_cyc[0] = cyc; if (refill) r0a = r0a + 1; else r0v = 0; end
    if (a1) begin hs_cyc[1] = cyc; if (refill) r1a = r1a + 1; else r1v = 0; end
  endtask

  task automatic wait_rsp(int n);
    for (int i = 0; i < 200 && rq.size() < n; i++) step();
    chk("rsp_count", rq.size(), n);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_req0_ready"}, r0rdy, 0);
    chk({tag, "_req1_ready"}, r1rdy, 0);
    chk({tag, "_rsp_valid"}, rsp_v, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_flags"}, rsp_flags, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_fun"}, alu_fun, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int k;
    // Reset state, with a valid request present to show READY is suppressed
    r0v = 1;
    @(posedge clk); #1;
    chk_zero("reset");
    r0v = 0;
    @(posedge clk); #1 rst_n = 1;

    // Single ADD 6+7
    r0a = 16'd6; r0b = 16'd7; r0f = 4'd0; r0v = 1;
    wait_rsp(1);
    chk("add_id", rq[0].id, 0);
    chk("add_data", rq[0].data, 16'd13);
    chk("add_flags", rq[0].flags, 5'b01000);
    chk("add_err", rq[0].err, 0);
    chk("add_lat", rq[0].lat, 2);
    rq.delete();

    // Continuous tie after reset: grants alternate starting with REQ0
    do_reset();
    r0a = 16'd15; r0b = 16'd4; r0f = 4'd1;
    r1a = 16'd4;  r1b = 16'd3; r1f = 4'd2;
    refill = 1; r0v = 1; r1v = 1;
    wait_rsp(4);
    refill = 0; r0v = 0; r1v = 0;
    repeat (6) step();
    chk("tie0_id", rq[0].id, 0); chk("tie0_data", rq[0].data, 16'd11);
    chk("tie1_id", rq[1].id, 1); chk("tie1_data", rq[1].data, 16'd12);
    chk("tie2_id", rq[2].id, 0); chk("tie2_data", rq[2].data, 16'd12);
    chk("tie3_id", rq[3].id, 1); chk("tie3_data", rq[3].data, 16'd15);
    chk("tie_count", rq.size(), 4);
    rq.delete();

    // XOR under back-pressure while REQ1 waits
    rsp_rdy = 0;
    r0a = 16'hAAAA; r0b = 16'h5555; r0f = 4'd6; r0v = 1;
    step();
    r1a = 16'd1; r1b = 16'd2; r1f = 4'd5; r1v = 1;
    for (int i = 0; i < 10 && !rsp_v; i++) step();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", rsp_v, 1);
      chk("bp_data", rsp_data, 16'hFFFF);
      chk("bp_req1_ready", r1rdy, 0);
    end
    @(posedge clk); #1 rsp_rdy = 1;
    wait_rsp(2);
    chk("xor_id", rq[0].id, 0); chk("xor_data", rq[0].data, 16'hFFFF);
    chk("xor_flags", rq[0].flags, 5'b00100);
    chk("or_id", rq[1].id, 1); chk("or_data", rq[1].data, 16'd3);
    rq.delete();

    // Screening: divide by zero, function 1111, and a legal divide
    r1a = 16'd14; r1b = 16'd0; r1f = 4'd3; r1v = 1;
    wait_rsp(1);
    chk("div0_id", rq[0].id, 1); chk("div0_data", rq[0].data, 0);
    chk("div0_flags", rq[0].flags, 0); chk("div0_err", rq[0].err, 1);
    chk("div0_lat", rq[0].lat, 1);
    chk("div0_alu_fun", alu_fun, 4'd5);
    r1a = 16'd14; r1b = 16'd9; r1f = 4'hF; r1v = 1;
    wait_rsp(2);
    chk("f15_id", rq[1].id, 1); chk("f15_data", rq[1].data, 0);
    chk("f15_err", rq[1].err, 1); chk("f15_lat", rq[1].lat, 1);
    chk("f15_alu_b", alu_b, 16'd2);
    r0a = 16'd14; r0b = 16'd7; r0f = 4'd3; r0v = 1;
    wait_rsp(3);
    chk("div_data", rq[2].data, 16'd2); chk("div_err", rq[2].err, 0);
    rq.delete();

    // Asynchronous reset during EXEC of CMPG F>A
    r1a = 16'hF; r1b = 16'hA; r1f = 4'd7; r1v = 1;
    step();
    r1v = 1;
    #1 rst_n = 0;
    #1 chk_zero("rst_exec");
    r1v = 0;
    @(posedge clk); #1 rst_n = 1;
    repeat (6) step();
    chk("rst_no_rsp", rq.size(), 0);
    r0a = 16'd1; r0b = 16'd1; r0f = 4'd0;
    r1a = 16'd2; r1b = 16'd2; r1f = 4'd0;
    r0v = 1; r1v = 1;
    wait_rsp(2);
    chk("post_rst0_id", rq[0].id, 0); chk("post_rst0_data", rq[0].data, 16'd2);
    chk("post_rst1_id", rq[1].id, 1); chk("post_rst1_data", rq[1].data, 16'd4);
    rq.delete();

    // ALU_LAT = 3 instance: SHL 6 by 1
    @(posedge clk); #1;
    s_a = 16'd6; s_b = 16'd1; s_f = 4'd8; s_v = 1;
    @(negedge clk);
    chk("lat3_ready", s_rdy, 1);
    @(posedge clk); #1;
    k = cyc;
    s_v = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lat3_alu_a", s_alu_a, 16'd6);
      chk("lat3_alu_fun", s_alu_fun, 4'd8);
      chk("lat3_valid_low", s_rsp_v, 0);
    end
    @(negedge clk);
    chk("lat3_valid", s_rsp_v, 1);
    chk("lat3_lat", cyc - k, 4);
    chk("lat3_data", s_rsp_data, 16'd12);
    chk("lat3_flags", s_rsp_flags, 5'b00001);
    chk("lat3_err", s_rsp_err, 0);
    chk("lat3_id", s_rsp_id, 0);
    $display("lat3 rsp data=%h flags=%b", s_rsp_data, s_rsp_flags);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
